// File: rtl/write_module.sv
// Write-side controller for the asynchronous FIFO: valid/ready intake into a
// 2-entry skid buffer, drained into the FIFO write port while wfull is low.
module write_module #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              wclk,
    input  logic              Wrst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              wfull,
    output logic              winc,
    output logic [DATA_W-1:0] wdata,
    output logic [CNT_W-1:0]  word_count
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_active;
    logic [DATA_W-1:0]   r_slot0;
    logic [DATA_W-1:0]   r_slot1;
    logic [CNT_W-1:0]    r_count;

    state_t              w_state_nxt;
    logic [DATA_W-1:0]   w_slot0_nxt;
    logic [DATA_W-1:0]   w_slot1_nxt;
    logic                w_push;
    logic                w_pop;

    // r_active holds in_ready low until the first edge after reset release,
    // keeping in_ready a pure function of registers.
    assign in_ready   = r_active && (r_state == ST_EMPTY || r_state == ST_ONE);
    assign winc       = (r_state == ST_ONE || r_state == ST_TWO) && !wfull;
    assign wdata      = r_slot0;
    assign word_count = r_count;

    assign w_push = in_valid && in_ready;
    assign w_pop  = winc;

    // NOTE: every signal gets a default before the case so no path through
    // the block leaves it unassigned, which would infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_slot0_nxt = r_slot0;
        w_slot1_nxt = r_slot1;
        case (r_state)
            ST_EMPTY: begin
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                    w_slot0_nxt = in_data;
                end
            end
            ST_ONE: begin
                if (w_push && w_pop) begin
                    w_slot0_nxt = in_data;
                end else if (w_push) begin
                    w_state_nxt = ST_TWO;
                    w_slot1_nxt = in_data;
                end else if (w_pop) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                    w_slot0_nxt = r_slot1;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop samples the
    // pre-edge values regardless of statement order.
    always_ff @(posedge wclk or negedge Wrst_n) begin
        if (!Wrst_n) begin
            r_state  <= ST_EMPTY;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_active <= 1'b1;
        end
    end

    // NOTE: the slots are reset on purpose: wdata must read 0 during reset,
    // so this storage cannot be left as reset-less data registers.
    always_ff @(posedge wclk or negedge Wrst_n) begin
        if (!Wrst_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
        end else begin
            r_slot0 <= w_slot0_nxt;
            r_slot1 <= w_slot1_nxt;
        end
    end

    always_ff @(posedge wclk or negedge Wrst_n) begin
        if (!Wrst_n) begin
            r_count <= '0;
        end else if (winc) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_write_module.sv
// Directed bench for write_module: inputs driven and outputs sampled on the
// falling edge; FIFO writes are logged and compared with expected word lists.
module tb_write_module;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;

    logic              wclk;
    logic              Wrst_n;
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              wfull;
    logic              winc;
    logic [DATA_W-1:0] wdata;
    logic [CNT_W-1:0]  word_count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] written[$];

    write_module #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .wclk       (wclk),
        .Wrst_n     (Wrst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .wfull      (wfull),
        .winc       (winc),
        .wdata      (wdata),
        .word_count (word_count)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Log the word the FIFO will take at the coming rising edge.
    always @(negedge wclk) begin
        #2;
        if (winc === 1'b1) written.push_back(wdata);
    end

    task automatic check_log(input string name, input logic [DATA_W-1:0] exp[$]);
        n_checks++;
        if (written.size() != exp.size()) begin
            n_fail++;
            $display("FAIL %s_len: got %0d words, want %0d", name, written.size(), exp.size());
        end else begin
            for (int i = 0; i < exp.size(); i++) begin
                n_checks++;
                if (written[i] !== exp[i]) begin
                    n_fail++;
                    $display("FAIL %s_word[%0d]: got %h want %h", name, i, written[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        Wrst_n = 1'b0; in_valid = 1'b0; in_data = '0; wfull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk); #1;
            n_checks++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", in_ready); end
            n_checks++;
            if (winc !== 1'b0) begin n_fail++; $display("FAIL rst_winc: got %b want 0", winc); end
        end
        Wrst_n = 1'b1;
        @(negedge wclk); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
        n_checks++;
        if (winc !== 1'b0) begin n_fail++; $display("FAIL post_rst_winc: got %b want 0", winc); end
        n_checks++;
        if (word_count !== 4'd0) begin n_fail++; $display("FAIL post_rst_count: got %0d want 0", word_count); end
        n_checks++;
        if (wdata !== 16'h0000) begin n_fail++; $display("FAIL post_rst_wdata: got %h want 0000", wdata); end
    endtask

    task automatic test_streaming;
        logic [DATA_W-1:0] exp[$];
        written.delete();
        for (int k = 0; k < 8; k++) begin
            @(negedge wclk);
            in_valid = 1'b1; in_data = 16'(k + 1); wfull = 1'b0;
            #1;
            n_checks++;
            if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_ready k=%0d: got %b want 1", k, in_ready); end
            n_checks++;
            if (winc !== (k != 0)) begin n_fail++; $display("FAIL stream_winc k=%0d: got %b want %b", k, winc, k != 0); end
            if (k != 0) begin
                n_checks++;
                if (wdata !== 16'(k)) begin n_fail++; $display("FAIL stream_wdata k=%0d: got %h want %h", k, wdata, 16'(k)); end
            end
        end
        @(negedge wclk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (winc !== 1'b1 || wdata !== 16'h0008) begin
            n_fail++; $display("FAIL stream_last: got winc=%b wdata=%h want 1/0008", winc, wdata);
        end
        @(negedge wclk); #1;
        n_checks++;
        if (winc !== 1'b0) begin n_fail++; $display("FAIL stream_idle_winc: got %b want 0", winc); end
        n_checks++;
        if (word_count !== 4'd8) begin n_fail++; $display("FAIL stream_count: got %0d want 8", word_count); end
        for (int i = 1; i <= 8; i++) exp.push_back(16'(i));
        check_log("stream", exp);
    endtask

    task automatic test_backpressure;
        logic [DATA_W-1:0] exp[$] = '{16'hA1A1, 16'hB2B2, 16'hC3C3};
        written.delete();
        @(negedge wclk);
        wfull = 1'b1; in_valid = 1'b1; in_data = 16'hA1A1;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || winc !== 1'b0) begin
            n_fail++; $display("FAIL bp_first: got ready=%b winc=%b want 1/0", in_ready, winc);
        end
        @(negedge wclk);
        in_data = 16'hB2B2;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || winc !== 1'b0 || wdata !== 16'hA1A1) begin
            n_fail++; $display("FAIL bp_second: got ready=%b winc=%b wdata=%h want 1/0/a1a1", in_ready, winc, wdata);
        end
        @(negedge wclk);
        in_data = 16'hC3C3;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || winc !== 1'b0 || wdata !== 16'hA1A1) begin
            n_fail++; $display("FAIL bp_full: got ready=%b winc=%b wdata=%h want 0/0/a1a1", in_ready, winc, wdata);
        end
        @(negedge wclk); #1;
        n_checks++;
        if (in_ready !== 1'b0 || winc !== 1'b0) begin
            n_fail++; $display("FAIL bp_hold: got ready=%b winc=%b want 0/0", in_ready, winc);
        end
        @(negedge wclk);
        wfull = 1'b0;
        #1;
        n_checks++;
        if (winc !== 1'b1 || wdata !== 16'hA1A1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL bp_resume: got winc=%b wdata=%h ready=%b want 1/a1a1/0", winc, wdata, in_ready);
        end
        @(negedge wclk); #1;
        n_checks++;
        if (winc !== 1'b1 || wdata !== 16'hB2B2 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_drain2: got winc=%b wdata=%h ready=%b want 1/b2b2/1", winc, wdata, in_ready);
        end
        @(negedge wclk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (winc !== 1'b1 || wdata !== 16'hC3C3) begin
            n_fail++; $display("FAIL bp_drain3: got winc=%b wdata=%h want 1/c3c3", winc, wdata);
        end
        @(negedge wclk); #1;
        n_checks++;
        if (word_count !== 4'd11) begin n_fail++; $display("FAIL bp_count: got %0d want 11", word_count); end
        check_log("bp", exp);
    endtask

    task automatic test_simultaneous;
        logic [DATA_W-1:0] exp[$] = '{16'h1111, 16'h2222};
        written.delete();
        @(negedge wclk);
        in_valid = 1'b1; in_data = 16'h1111; wfull = 1'b0;
        @(negedge wclk);
        in_data = 16'h2222;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || winc !== 1'b1 || wdata !== 16'h1111) begin
            n_fail++; $display("FAIL pp_one: got ready=%b winc=%b wdata=%h want 1/1/1111", in_ready, winc, wdata);
        end
        @(negedge wclk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || winc !== 1'b1 || wdata !== 16'h2222) begin
            n_fail++; $display("FAIL pp_stay_one: got ready=%b winc=%b wdata=%h want 1/1/2222", in_ready, winc, wdata);
        end
        @(negedge wclk); #1;
        n_checks++;
        if (winc !== 1'b0 || word_count !== 4'd13) begin
            n_fail++; $display("FAIL pp_end: got winc=%b count=%0d want 0/13", winc, word_count);
        end
        check_log("pp", exp);
    endtask

    task automatic test_reset_mid;
        logic [DATA_W-1:0] exp[$];
        @(negedge wclk);
        wfull = 1'b1; in_valid = 1'b1; in_data = 16'h5555;
        @(negedge wclk);
        in_data = 16'h6666;
        @(negedge wclk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (in_ready !== 1'b0 || wdata !== 16'h5555) begin
            n_fail++; $display("FAIL mid_two: got ready=%b wdata=%h want 0/5555", in_ready, wdata);
        end
        #2;
        Wrst_n = 1'b0;
        #1;
        n_checks++;
        if (winc !== 1'b0 || wdata !== 16'h0000 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL mid_async: got winc=%b wdata=%h ready=%b want 0/0000/0", winc, wdata, in_ready);
        end
        written.delete();
        @(negedge wclk);
        wfull = 1'b0;
        Wrst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge wclk); #1;
            n_checks++;
            if (winc !== 1'b0 || word_count !== 4'd0) begin
                n_fail++; $display("FAIL mid_after i=%0d: got winc=%b count=%0d want 0/0", i, winc, word_count);
            end
        end
        check_log("mid", exp);
    endtask

    task automatic test_counter_wrap;
        logic [DATA_W-1:0] exp[$];
        logic [CNT_W-1:0]  exp_cnt;
        written.delete();
        for (int k = 0; k < 17; k++) begin
            @(negedge wclk);
            in_valid = 1'b1; in_data = 16'h0100 + 16'(k); wfull = 1'b0;
            exp.push_back(16'h0100 + 16'(k));
            #1;
            exp_cnt = (k >= 1) ? CNT_W'(k - 1) : '0;
            n_checks++;
            if (word_count !== exp_cnt) begin
                n_fail++; $display("FAIL wrap_count k=%0d: got %0d want %0d", k, word_count, exp_cnt);
            end
        end
        @(negedge wclk);
        in_valid = 1'b0;
        #1;
        n_checks++;
        if (word_count !== 4'd0) begin n_fail++; $display("FAIL wrap_zero: got %0d want 0", word_count); end
        @(negedge wclk); #1;
        n_checks++;
        if (word_count !== 4'd1) begin n_fail++; $display("FAIL wrap_one: got %0d want 1", word_count); end
        check_log("wrap", exp);
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_reset_mid();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
